// File: rtl/lfsr_shift_engine_if.sv
// Control/data bundle between the pattern logic and the shift/LFSR engine.
// Signal names keep their direction prefixes because they are the block's public port names.
interface lfsr_shift_engine_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] i_num;
  logic             i_load;
  logic             i_run;
  logic             i_step;
  logic [2:0]       i_mode;
  logic [WIDTH-1:0] o_num;
  logic             o_step;
  logic             o_reseed;
  logic             o_zero;

  modport master (
    output i_num, i_load, i_run, i_step, i_mode,
    input  o_num, o_step, o_reseed, o_zero
  );

  modport slave (
    input  i_num, i_load, i_run, i_step, i_mode,
    output o_num, o_step, o_reseed, o_zero
  );
endinterface

// File: rtl/lfsr_shift_engine.sv
// Mode-selectable WIDTH-bit shift/LFSR register with a prescaled free-run advance,
// single-step, synchronous load and LFSR lock-up reseed.
module lfsr_shift_engine #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter int unsigned      DIV   = 5000000
) (
  input logic                clk,
  input logic                rst,
  lfsr_shift_engine_if.slave bus
);

  localparam int unsigned      CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [2:0]       MODE_LFSR = 3'b001;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] state;
  logic             step_p1;
  logic             reseed_p1;
  logic             ptick;
  logic             advance;
  logic             lockup;

  // One-bit move of the current state; an all-zero LFSR is reseeded instead of stuck.
  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] s,
                                                   input logic [2:0]       mode);
    logic signed [WIDTH-1:0] s_signed;
    logic        [WIDTH-1:0] r;
    s_signed = s;
    case (mode)
      3'b001:  r = (s == '0) ? SEED : {^(s & TAPS), s[WIDTH-1:1]};
      3'b010:  r = {1'b0, s[WIDTH-1:1]};
      3'b011:  r = {s[WIDTH-2:0], 1'b0};
      3'b100:  r = {s[0], s[WIDTH-1:1]};
      3'b101:  r = {s[WIDTH-2:0], s[WIDTH-1]};
      3'b110:  r = s_signed >>> 1;
      default: r = s;
    endcase
    return r;
  endfunction

  assign ptick   = bus.i_run && (count == CNT_MAX);
  assign advance = ptick || bus.i_step;
  assign lockup  = advance && (bus.i_mode == MODE_LFSR) && (state == '0);

  // Prescaler: holds while paused, restarts on load so the next tick is a full period away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (bus.i_load) begin
      count <= '0;
    end else if (bus.i_run) begin
      count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
    end
  end

  // Stage p0 -> p1: register update and the one-cycle step/reseed strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEED;
      step_p1   <= 1'b0;
      reseed_p1 <= 1'b0;
    end else begin
      step_p1   <= advance && !bus.i_load;
      reseed_p1 <= lockup && !bus.i_load;
      if (bus.i_load) begin
        state <= bus.i_num;
      end else if (advance) begin
        state <= shift_next(state, bus.i_mode);
      end
    end
  end

  assign bus.o_num    = state;
  assign bus.o_step   = step_p1;
  assign bus.o_reseed = reseed_p1;
  assign bus.o_zero   = (state == '0);

endmodule

// File: tb/tb_lfsr_shift_engine.sv
// Bench for lfsr_shift_engine (WIDTH=8, TAPS=1D, SEED=01, DIV=4) against an arithmetic model.
module tb_lfsr_shift_engine;

  localparam int W      = 8;
  localparam int TAPS_I = 'h1D;
  localparam int SEED_I = 1;
  localparam int DIV_I  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lfsr_shift_engine_if #(.WIDTH(W)) dut_bus ();

  lfsr_shift_engine #(
    .WIDTH(W),
    .TAPS (8'h1D),
    .SEED (8'h01),
    .DIV  (DIV_I)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_num;
  int m_cnt;
  bit m_step;
  bit m_reseed;

  // Next value written as plain arithmetic on an 8-bit unsigned number.
  function automatic int model_next(int s, int mode);
    case (mode)
      1:       return (s == 0) ? SEED_I : (($countones(s & TAPS_I) % 2) * 128 + s / 2);
      2:       return s / 2;
      3:       return (s * 2) % 256;
      4:       return s / 2 + (s % 2) * 128;
      5:       return (s * 2) % 256 + s / 128;
      6:       return s / 2 + (s & 128);
      default: return s;
    endcase
  endfunction

  task automatic model_reset();
    m_num    = SEED_I;
    m_cnt    = 0;
    m_step   = 1'b0;
    m_reseed = 1'b0;
  endtask

  // Advance the model with the inputs present at this edge, then let the DUT take the edge.
  task automatic clk_cycle();
    bit ptick;
    bit adv;
    ptick = dut_bus.i_run && (m_cnt == DIV_I - 1);
    adv   = ptick || dut_bus.i_step;
    if (dut_bus.i_load) begin
      m_num    = int'(dut_bus.i_num);
      m_cnt    = 0;
      m_step   = 1'b0;
      m_reseed = 1'b0;
    end else begin
      m_step   = adv;
      m_reseed = adv && (dut_bus.i_mode == 3'd1) && (m_num == 0);
      if (dut_bus.i_run) m_cnt = (m_cnt + 1) % DIV_I;
      if (adv) m_num = model_next(m_num, int'(dut_bus.i_mode));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    rst = 1'b0;
    #1;
    checks++;
    if ({dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero} !== {8'h01, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got num=%h step=%b reseed=%b zero=%b want num=01 step=0 reseed=0 zero=0",
               dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_lfsr_run();
    int pulses;
    pulses = 0;
    dut_bus.i_mode = 3'b001;
    dut_bus.i_run  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      clk_cycle();
      pulses += int'(dut_bus.o_step);
      checks++;
      if ({dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero} !==
          {m_num[7:0], m_step, m_reseed, (m_num == 0)}) begin
        errors++;
        $display("FAIL lfsr_run cyc%0d got %h/%b%b%b want %h/%b%b%b", i, dut_bus.o_num,
                 dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero, m_num[7:0], m_step, m_reseed,
                 (m_num == 0));
      end
      if (i == 4 || i == 8) begin
        checks++;
        if (dut_bus.o_num !== ((i == 4) ? 8'h80 : 8'h40) || dut_bus.o_step !== 1'b1) begin
          errors++;
          $display("FAIL lfsr_run_value cyc%0d got num=%h step=%b want num=%h step=1", i,
                   dut_bus.o_num, dut_bus.o_step, (i == 4) ? 8'h80 : 8'h40);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL lfsr_run_pulses got %0d want 2", pulses);
    end
    dut_bus.i_run = 1'b0;
  endtask

  task automatic test_modes();
    logic [2:0] modes [7];
    logic [7:0] expv  [7];
    modes = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b111};
    expv  = '{8'h40, 8'h02, 8'hC0, 8'h03, 8'hC0, 8'h81, 8'h81};
    dut_bus.i_run = 1'b0;
    for (int k = 0; k < 7; k++) begin
      dut_bus.i_load = 1'b1;
      dut_bus.i_num  = 8'h81;
      clk_cycle();
      dut_bus.i_load = 1'b0;
      dut_bus.i_mode = modes[k];
      dut_bus.i_step = 1'b1;
      clk_cycle();
      dut_bus.i_step = 1'b0;
      checks++;
      if (dut_bus.o_num !== expv[k] || dut_bus.o_step !== 1'b1 || dut_bus.o_reseed !== 1'b0) begin
        errors++;
        $display("FAIL mode_%b got num=%h step=%b reseed=%b want num=%h step=1 reseed=0", modes[k],
                 dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed, expv[k]);
      end
    end
  endtask

  task automatic test_lockup();
    dut_bus.i_run  = 1'b0;
    dut_bus.i_load = 1'b1;
    dut_bus.i_num  = 8'h00;
    dut_bus.i_mode = 3'b001;
    clk_cycle();
    dut_bus.i_load = 1'b0;
    dut_bus.i_step = 1'b1;
    clk_cycle();
    dut_bus.i_step = 1'b0;
    checks++;
    if (dut_bus.o_num !== 8'h01 || dut_bus.o_reseed !== 1'b1 || dut_bus.o_zero !== 1'b0) begin
      errors++;
      $display("FAIL lockup_reseed got num=%h reseed=%b zero=%b want num=01 reseed=1 zero=0",
               dut_bus.o_num, dut_bus.o_reseed, dut_bus.o_zero);
    end
    clk_cycle();
    checks++;
    if (dut_bus.o_reseed !== 1'b0 || dut_bus.o_step !== 1'b0) begin
      errors++;
      $display("FAIL lockup_pulse_len got reseed=%b step=%b want 0 0", dut_bus.o_reseed,
               dut_bus.o_step);
    end
    dut_bus.i_load = 1'b1;
    dut_bus.i_num  = 8'h00;
    dut_bus.i_mode = 3'b010;
    clk_cycle();
    dut_bus.i_load = 1'b0;
    dut_bus.i_step = 1'b1;
    clk_cycle();
    dut_bus.i_step = 1'b0;
    checks++;
    if (dut_bus.o_num !== 8'h00 || dut_bus.o_reseed !== 1'b0 || dut_bus.o_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_no_reseed got num=%h reseed=%b zero=%b want num=00 reseed=0 zero=1",
               dut_bus.o_num, dut_bus.o_reseed, dut_bus.o_zero);
    end
  endtask

  task automatic test_priority();
    dut_bus.i_mode = 3'b010;
    dut_bus.i_run  = 1'b1;
    for (int g = 0; g < 8 && m_cnt != DIV_I - 1; g++) clk_cycle();
    dut_bus.i_load = 1'b1;
    dut_bus.i_num  = 8'hAA;
    dut_bus.i_step = 1'b1;
    clk_cycle();
    dut_bus.i_load = 1'b0;
    dut_bus.i_step = 1'b0;
    checks++;
    if (dut_bus.o_num !== 8'hAA || dut_bus.o_step !== 1'b0) begin
      errors++;
      $display("FAIL load_priority got num=%h step=%b want num=aa step=0", dut_bus.o_num,
               dut_bus.o_step);
    end
    for (int i = 1; i <= 4; i++) begin
      clk_cycle();
      checks++;
      if (dut_bus.o_step !== (i == 4) || dut_bus.o_num !== ((i == 4) ? 8'h55 : 8'hAA)) begin
        errors++;
        $display("FAIL count_restart cyc%0d got num=%h step=%b want num=%h step=%b", i,
                 dut_bus.o_num, dut_bus.o_step, (i == 4) ? 8'h55 : 8'hAA, (i == 4));
      end
    end
    for (int i = 0; i < 3; i++) clk_cycle();
    dut_bus.i_step = 1'b1;
    clk_cycle();
    dut_bus.i_step = 1'b0;
    checks++;
    if (dut_bus.o_num !== 8'h2A || dut_bus.o_step !== 1'b1) begin
      errors++;
      $display("FAIL step_with_ptick got num=%h step=%b want num=2a step=1", dut_bus.o_num,
               dut_bus.o_step);
    end
    clk_cycle();
    checks++;
    if (dut_bus.o_num !== 8'h2A || dut_bus.o_step !== 1'b0) begin
      errors++;
      $display("FAIL step_with_ptick_after got num=%h step=%b want num=2a step=0", dut_bus.o_num,
               dut_bus.o_step);
    end
  endtask

  task automatic test_pause();
    int held;
    dut_bus.i_mode = 3'b000;
    dut_bus.i_run  = 1'b1;
    for (int g = 0; g < 8 && m_cnt != 2; g++) clk_cycle();
    held = int'(dut_bus.o_num);
    dut_bus.i_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      checks++;
      if (dut_bus.o_step !== 1'b0 || int'(dut_bus.o_num) != held) begin
        errors++;
        $display("FAIL pause_hold cyc%0d got num=%h step=%b want num=%h step=0", i, dut_bus.o_num,
                 dut_bus.o_step, held[7:0]);
      end
    end
    dut_bus.i_run = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      clk_cycle();
      checks++;
      if (dut_bus.o_step !== (i == 2) || int'(dut_bus.o_num) != held) begin
        errors++;
        $display("FAIL pause_resume cyc%0d got num=%h step=%b want num=%h step=%b", i,
                 dut_bus.o_num, dut_bus.o_step, held[7:0], (i == 2));
      end
    end
  endtask

  task automatic test_reset_midrun();
    dut_bus.i_load = 1'b1;
    dut_bus.i_num  = 8'h5A;
    dut_bus.i_mode = 3'b010;
    dut_bus.i_run  = 1'b1;
    clk_cycle();
    dut_bus.i_load = 1'b0;
    for (int i = 0; i < 6; i++) clk_cycle();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_bus.o_num !== 8'h01 || dut_bus.o_step !== 1'b0 || dut_bus.o_reseed !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got num=%h step=%b reseed=%b want num=01 step=0 reseed=0",
               dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    dut_bus.i_mode = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      clk_cycle();
      checks++;
      if (dut_bus.o_step !== (i == 4) || dut_bus.o_num !== ((i == 4) ? 8'h80 : 8'h01)) begin
        errors++;
        $display("FAIL reset_restart cyc%0d got num=%h step=%b want num=%h step=%b", i,
                 dut_bus.o_num, dut_bus.o_step, (i == 4) ? 8'h80 : 8'h01, (i == 4));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      dut_bus.i_mode = 3'($urandom_range(0, 7));
      dut_bus.i_run  = ($urandom_range(0, 9) < 8);
      dut_bus.i_step = ($urandom_range(0, 3) == 0);
      dut_bus.i_load = ($urandom_range(0, 19) == 0);
      dut_bus.i_num  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      clk_cycle();
      checks++;
      if ({dut_bus.o_num, dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero} !==
          {m_num[7:0], m_step, m_reseed, (m_num == 0)}) begin
        errors++;
        $display("FAIL random cyc%0d got %h/%b%b%b want %h/%b%b%b", i, dut_bus.o_num,
                 dut_bus.o_step, dut_bus.o_reseed, dut_bus.o_zero, m_num[7:0], m_step, m_reseed,
                 (m_num == 0));
      end
    end
    dut_bus.i_load = 1'b0;
    dut_bus.i_step = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dut_bus.i_num  = '0;
    dut_bus.i_load = 1'b0;
    dut_bus.i_run  = 1'b0;
    dut_bus.i_step = 1'b0;
    dut_bus.i_mode = 3'b000;
    model_reset();
    test_reset();
    test_lfsr_run();
    test_modes();
    test_lockup();
    test_priority();
    test_pause();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_shift_engine.md
Name: lfsr_shift_engine

Overview:
- Parametrised, mode-selectable shift/LFSR register with a built-in tick prescaler. Next generation of the LED-pattern shifter in the digital labs.
- Widens the register to WIDTH bits and makes the feedback taps configurable.
- Adds logical, arithmetic and rotate modes, single-step, synchronous load, LFSR lock-up recovery and a step-strobe output.
- Drives LED/seven-segment pattern logic on the board.

Parameters:
- WIDTH, 8: register width in bits, 2..32.
- TAPS, 8'h1D: feedback mask (WIDTH bits). Bit k set means state[k] feeds the XOR. Default taps are bits 4, 3, 2, 0.
- SEED, 8'h01: reset value and lock-up reseed value (WIDTH bits). Must be non-zero.
- DIV, 5000000: prescaler period in clk cycles, at least 1. Free-run advance occurs once per DIV cycles.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- i_num, in, WIDTH: parallel load value.
- i_load, in, 1: synchronous load strobe.
- i_run, in, 1: enables free-running advance from the prescaler.
- i_step, in, 1: one-cycle single-step request.
- i_mode, in, 3: shift mode (encoding below).
- o_num, out, WIDTH: register state.
- o_step, out, 1: one-cycle pulse in the cycle after each advance.
- o_reseed, out, 1: one-cycle pulse in the cycle after a lock-up reseed.
- o_zero, out, 1: combinational, high when o_num == 0.

Behaviour:
- Reset (rst=0, asynchronous): o_num=SEED, prescaler count=0, o_step=0, o_reseed=0.
- Reset takes effect immediately at any point, including mid-count; the count restarts from 0 on release.
- Prescaler: count runs 0..DIV-1 and wraps to 0.
  - It counts only while i_run=1; it holds its value while i_run=0.
  - ptick = i_run && count==DIV-1.
  - With DIV=1, ptick=i_run on every cycle.
- advance = ptick OR i_step. If both are high in the same cycle, exactly one advance occurs.
- Priority, highest first: i_load, then advance, then hold.
- i_load=1:
  - o_num <= i_num and count <= 0.
  - Any advance in that cycle is discarded, and o_step stays 0 next cycle.
- Advance by i_mode (all shifts are by 1 bit; "s" is the current state):
  - 000 hold: o_num unchanged, but o_step still pulses.
  - 001 LFSR: fb = XOR-reduce(s & TAPS); next = {fb, s[WIDTH-1:1]}.
  - 010 logical right: {1'b0, s[WIDTH-1:1]}.
  - 011 logical left: {s[WIDTH-2:0], 1'b0}.
  - 100 rotate right: {s[0], s[WIDTH-1:1]}.
  - 101 rotate left: {s[WIDTH-2:0], s[WIDTH-1]}.
  - 110 arithmetic right: {s[WIDTH-1], s[WIDTH-1:1]}.
  - 111 reserved: behaves as hold.
- Lock-up recovery: in mode 001, an advance with s==0 loads SEED instead of computing feedback, and o_reseed pulses the following cycle. No other mode reseeds.
- o_step and o_reseed are registered: high for exactly the one cycle after the qualifying edge.
- i_mode may change on any cycle. The value sampled at the advance edge is the one used.
- o_num changes only on load, advance, or reset.

Test Plan:
Configuration for all cases: WIDTH=8, TAPS=8'h1D, SEED=8'h01, DIV=4.
- Reset and LFSR run: pulse rst low asynchronously, mode 001, i_run=1 → o_num=01, then 80 after 4 clks, then 40 after 4 more. o_step pulses once per 4 cycles.
- Each mode via i_step, loading 8'h81 before each → 010 gives 40, 011 gives 02, 100 gives C0, 101 gives 03, 110 gives C0, 000 gives 81 with o_step=1.
- Lock-up: load 00, mode 001, one step → o_num=01, o_reseed=1 for one cycle. Mode 010 from 00 → stays 00, no reseed, o_zero=1.
- Priority: i_load=1 with i_num=AA on the same cycle as i_step and ptick → o_num=AA, o_step=0, count restarts (next ptick 4 cycles later). i_step coinciding with ptick → exactly one shift.
- Pause: drop i_run at count=2 for 10 cycles, then raise it → advance occurs exactly 2 cycles after resume.
- Reset mid-run: assert rst between clock edges → o_num=01 immediately, without waiting for clk. After release, the first advance occurs after 4 cycles.
